time_set_ctrl: RTL

- Button-driven controller that sequences loading of the clock/alarm datapath.
- The user selects a target (time or alarm), steps hours, then minutes, in BCD, and confirms.
- The block then drives the H_in/M_in digit buses and holds LD_time or LD_alarm long enough to be captured by the datapath's divided 1 s clock (10:1 divider).
- It sits between the debounced front-panel buttons and the clock/alarm datapath.

---
 rtl/time_set_ctrl_pkg.sv | 30 +++
 rtl/time_set_ctrl_bcd_field_inc.sv | 37 +++
 rtl/time_set_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl_pkg
// Purpose  : Shared types and BCD limits for the time/alarm set controller.
// Revision : 1.0 - initial release
// ============================================================================
package time_set_ctrl_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EDIT_H = 2'd1,
    EDIT_M = 2'd2,
    LOAD   = 2'd3
  } state_t;

  // Which datapath register the session will load
  typedef enum logic {
    TIME  = 1'b0,
    ALARM = 1'b1
  } target_t;

  // BCD wrap points: hours wrap after 23, minutes after 59
  localparam int HOUR_MAX_TENS       = 2;
  localparam int HOUR_MAX_UNITS_AT_2 = 3;
  localparam int MIN_MAX_TENS        = 5;
  localparam int BCD_MAX_DIGIT       = 9;

endpackage
`default_nettype wire

// File: rtl/time_set_ctrl_bcd_field_inc.sv
`default_nettype none
// ============================================================================
// Module   : bcd_field_inc
// Purpose  : Combinational BCD +1 for a tens/units pair with a configurable
//            wrap point (e.g. 23 -> 00 or 59 -> 00).
// Revision : 1.0 - initial release
// ============================================================================
module bcd_field_inc #(
  parameter int TENS_W           = 4,
  parameter int MAX_TENS         = 5,
  parameter int MAX_UNITS_AT_TOP = 9
) (
  input  logic [TENS_W-1:0] tens,
  input  logic [3:0]        units,
  output logic [TENS_W-1:0] tens_next,
  output logic [3:0]        units_next
);

  localparam logic [TENS_W-1:0] TOP_TENS  = TENS_W'(MAX_TENS);
  localparam logic [3:0]        TOP_UNITS = 4'(MAX_UNITS_AT_TOP);
  localparam logic [TENS_W-1:0] TENS_ONE  = TENS_W'(1);

  // Wrap at the top value, carry units 9 into tens, otherwise bump units
  always_comb begin
    tens_next  = tens;
    units_next = units + 4'd1;
    if (tens == TOP_TENS && units == TOP_UNITS) begin
      tens_next  = '0;
      units_next = 4'd0;
    end else if (units == 4'd9) begin
      tens_next  = tens + TENS_ONE;
      units_next = 4'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/time_set_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_set_ctrl
// Purpose  : Button-driven editor for clock time / alarm. Steps hours then
//            minutes in BCD and holds a load strobe long enough for the
//            datapath's divided 1 s clock to capture it.
// Revision : 1.0 - initial release
// ============================================================================
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int LD_HOLD = 12,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_set_time,
  input  logic       btn_set_alarm,
  input  logic       btn_inc,
  input  logic       btn_next,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       edit_hour,
  output logic       edit_min,
  output logic       busy
);

  localparam int HOLD_W = $clog2(LD_HOLD + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LD_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  state_t            state;
  target_t           target;
  logic [HOLD_W-1:0] hold_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic prev_set_time, prev_set_alarm, prev_inc, prev_next;
  logic edge_set_time, edge_set_alarm, edge_inc, edge_next;

  logic [1:0] h_tens_next;
  logic [3:0] h_units_next, m_tens_next, m_units_next;

  // Rising-edge detection against last cycle's button levels
  assign edge_set_time  = btn_set_time  & ~prev_set_time;
  assign edge_set_alarm = btn_set_alarm & ~prev_set_alarm;
  assign edge_inc       = btn_inc       & ~prev_inc;
  assign edge_next      = btn_next      & ~prev_next;

  bcd_field_inc #(
    .TENS_W           (2),
    .MAX_TENS         (HOUR_MAX_TENS),
    .MAX_UNITS_AT_TOP (HOUR_MAX_UNITS_AT_2)
  ) u_hour_inc (
    .tens       (H_in1),
    .units      (H_in0),
    .tens_next  (h_tens_next),
    .units_next (h_units_next)
  );

  bcd_field_inc #(
    .TENS_W           (4),
    .MAX_TENS         (MIN_MAX_TENS),
    .MAX_UNITS_AT_TOP (BCD_MAX_DIGIT)
  ) u_min_inc (
    .tens       (M_in1),
    .units      (M_in0),
    .tens_next  (m_tens_next),
    .units_next (m_units_next)
  );

  // Edit-session FSM with registered digits, strobes and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      target         <= TIME;
      hold_cnt       <= '0;
      to_cnt         <= '0;
      prev_set_time  <= 1'b1;
      prev_set_alarm <= 1'b1;
      prev_inc       <= 1'b1;
      prev_next      <= 1'b1;
      H_in1          <= 2'd0;
      H_in0          <= 4'd0;
      M_in1          <= 4'd0;
      M_in0          <= 4'd0;
      LD_time        <= 1'b0;
      LD_alarm       <= 1'b0;
      edit_hour      <= 1'b0;
      edit_min       <= 1'b0;
      busy           <= 1'b0;
    end else begin
      prev_set_time  <= btn_set_time;
      prev_set_alarm <= btn_set_alarm;
      prev_inc       <= btn_inc;
      prev_next      <= btn_next;

      case (state)
        IDLE: begin
          // set_time takes priority when both arrive together
          if (edge_set_time || edge_set_alarm) begin
            state     <= EDIT_H;
            target    <= edge_set_time ? TIME : ALARM;
            to_cnt    <= '0;
            edit_hour <= 1'b1;
            busy      <= 1'b1;
          end
        end

        EDIT_H: begin
          if (edge_inc) begin
            H_in1 <= h_tens_next;
            H_in0 <= h_units_next;
          end
          to_cnt <= (edge_inc || edge_next) ? '0 : to_cnt + 1'b1;
          if (edge_next) begin
            state     <= EDIT_M;
            edit_hour <= 1'b0;
            edit_min  <= 1'b1;
          end else if (!edge_inc && to_cnt == TO_LAST) begin
            state     <= IDLE;
            to_cnt    <= '0;
            edit_hour <= 1'b0;
            busy      <= 1'b0;
          end
        end

        EDIT_M: begin
          if (edge_inc) begin
            M_in1 <= m_tens_next;
            M_in0 <= m_units_next;
          end
          to_cnt <= (edge_inc || edge_next) ? '0 : to_cnt + 1'b1;
          if (edge_next) begin
            state    <= LOAD;
            to_cnt   <= '0;
            hold_cnt <= '0;
            edit_min <= 1'b0;
            LD_time  <= (target == TIME);
            LD_alarm <= (target == ALARM);
          end else if (!edge_inc && to_cnt == TO_LAST) begin
            state    <= IDLE;
            to_cnt   <= '0;
            edit_min <= 1'b0;
            busy     <= 1'b0;
          end
        end

        LOAD: begin
          // Strobe was raised on entry; drop it after LD_HOLD cycles
          if (hold_cnt == HOLD_LAST) begin
            state    <= IDLE;
            hold_cnt <= '0;
            LD_time  <= 1'b0;
            LD_alarm <= 1'b0;
            busy     <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
